// File: rtl/fsm_tb_pkg.sv
// Shared types for the stimulus sequencer: FSM states, default widths and the
// schedule entry layout.
package fsm_tb_pkg;

  localparam int unsigned TIME_W = 16;
  localparam int unsigned VEC_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [TIME_W-1:0] step_time;
    logic [VEC_W-1:0]  vec;
  } sched_entry_t;

endpackage

// File: rtl/stim_sequencer_regfile.sv
// Schedule storage: synchronous write, asynchronous read. Deliberately has no
// reset so the array maps onto plain flops without a reset tree.
module sched_regfile #(
  parameter int unsigned NUM_STEPS = 13,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned VEC_W     = 4,
  parameter int unsigned IDX_W     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [TIME_W-1:0] wtime,
  input  logic [VEC_W-1:0]  wvec,
  input  logic [IDX_W-1:0]  raddr,
  output logic [TIME_W-1:0] rd_time_c,
  output logic [VEC_W-1:0]  rd_vec_c
);

  localparam int unsigned ENTRY_W = TIME_W + VEC_W;

  logic [ENTRY_W-1:0] mem [NUM_STEPS];
  logic               raddr_ok;

  // Caller guarantees waddr is in range whenever we is set.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wtime, wvec};
    end
  end

  assign raddr_ok = ({1'b0, raddr} < (IDX_W+1)'(NUM_STEPS));

  always_comb begin
    rd_time_c = '0;
    rd_vec_c  = '0;
    if (raddr_ok) begin
      {rd_time_c, rd_vec_c} = mem[raddr];
    end
  end

endmodule

// File: rtl/stim_sequencer.sv
// Timed stimulus generator: replays a loaded (time, vector) schedule into a
// downstream sequence checker, one step per cycle at most.
module stim_sequencer #(
  parameter int unsigned NUM_STEPS = 13,
  parameter int unsigned TIME_W    = fsm_tb_pkg::TIME_W,
  parameter int unsigned VEC_W     = fsm_tb_pkg::VEC_W,
  parameter int unsigned IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [TIME_W-1:0] load_time,
  input  logic [VEC_W-1:0]  load_vec,
  input  logic [IDX_W:0]    num_steps,
  input  logic              start,
  input  logic              hold,
  input  logic              abort,
  output logic [VEC_W-1:0]  stim_vec,
  output logic              step_valid,
  output logic [IDX_W-1:0]  step_idx,
  output logic              busy,
  output logic              done
);

  import fsm_tb_pkg::*;

  state_e            state, state_n;
  logic [TIME_W-1:0] counter, counter_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [IDX_W:0]    count_lat, count_n;
  logic [VEC_W-1:0]  vec_n;
  logic              valid_n;
  logic [IDX_W-1:0]  sidx_n;
  logic              we_c;
  logic [IDX_W:0]    count_clamp_c;
  logic [TIME_W-1:0] rd_time_c;
  logic [VEC_W-1:0]  rd_vec_c;

  // Writes are accepted only outside a run and only for real entries.
  assign we_c = load_en && (state != RUN) &&
                ({1'b0, load_addr} < (IDX_W+1)'(NUM_STEPS));

  // Oversized counts would index past the register file; cap them.
  assign count_clamp_c = (num_steps > (IDX_W+1)'(NUM_STEPS)) ?
                         (IDX_W+1)'(NUM_STEPS) : num_steps;

  sched_regfile #(
    .NUM_STEPS (NUM_STEPS),
    .TIME_W    (TIME_W),
    .VEC_W     (VEC_W),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .we        (we_c),
    .waddr     (load_addr),
    .wtime     (load_time),
    .wvec      (load_vec),
    .raddr     (idx),
    .rd_time_c (rd_time_c),
    .rd_vec_c  (rd_vec_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      idx        <= '0;
      count_lat  <= '0;
      stim_vec   <= '0;
      step_valid <= 1'b0;
      step_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      counter    <= counter_n;
      idx        <= idx_n;
      count_lat  <= count_n;
      stim_vec   <= vec_n;
      step_valid <= valid_n;
      step_idx   <= sidx_n;
      busy       <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

  // Next-state and step issue; abort outranks start and step issue.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    idx_n     = idx;
    count_n   = count_lat;
    vec_n     = stim_vec;
    valid_n   = 1'b0;
    sidx_n    = step_idx;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            counter_n = '0;
            idx_n     = '0;
            count_n   = count_clamp_c;
            state_n   = (count_clamp_c == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!hold) begin
            if (counter >= rd_time_c) begin
              vec_n   = rd_vec_c;
              valid_n = 1'b1;
              sidx_n  = idx;
              idx_n   = idx + IDX_W'(1);
              if (((IDX_W+1)'(idx) + (IDX_W+1)'(1)) == count_lat) begin
                state_n = DONE;
              end
            end
            counter_n = (counter == '1) ? counter : counter + TIME_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: default instance plus a TIME_W=4
// instance used to exercise counter saturation.
module tb_stim_sequencer;

  import fsm_tb_pkg::*;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_time;
  logic [3:0]  load_vec;
  logic [4:0]  num_steps;
  logic        start;
  logic        start2;
  logic        hold;
  logic        abort;
  logic [3:0]  stim_vec;
  logic        step_valid;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done;
  logic [3:0]  load_time2;
  logic [3:0]  stim_vec2;
  logic        step_valid2;
  logic [3:0]  step_idx2;
  logic        busy2;
  logic        done2;

  int total = 0;
  int bad   = 0;

  assign load_time2 = load_time[3:0];

  stim_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_time  (load_time),
    .load_vec   (load_vec),
    .num_steps  (num_steps),
    .start      (start),
    .hold       (hold),
    .abort      (abort),
    .stim_vec   (stim_vec),
    .step_valid (step_valid),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done)
  );

  stim_sequencer #(.TIME_W(4)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_time  (load_time2),
    .load_vec   (load_vec),
    .num_steps  (num_steps),
    .start      (start2),
    .hold       (hold),
    .abort      (abort),
    .stim_vec   (stim_vec2),
    .step_valid (step_valid2),
    .step_idx   (step_idx2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input sched_entry_t e, input int addr);
    load_en   = 1'b1;
    load_addr = 4'(addr);
    load_time = e.step_time;
    load_vec  = e.vec;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic go(input int n);
    num_steps = 5'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int ev;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_time = '0; load_vec = '0;
    num_steps = '0; start = 1'b0; start2 = 1'b0; hold = 1'b0; abort = 1'b0;
    tick();
    tick();
    check("rst_vec",   32'(stim_vec),   0);
    check("rst_valid", 32'(step_valid), 0);
    check("rst_idx",   32'(step_idx),   0);
    check("rst_busy",  32'(busy),       0);
    check("rst_done",  32'(done),       0);
    reset = 1'b0;
    tick();

    // Basic run: {0:1, 2:3, 7:F}
    load('{step_time: 16'd0, vec: 4'h1}, 0);
    load('{step_time: 16'd2, vec: 4'h3}, 1);
    load('{step_time: 16'd7, vec: 4'hF}, 2);
    go(3);
    for (int c = 0; c <= 9; c++) begin
      ev = (c < 1) ? 0 : (c < 3) ? 1 : (c < 8) ? 3 : 15;
      check($sformatf("basic_vec c%0d", c),   32'(stim_vec),   ev);
      check($sformatf("basic_valid c%0d", c), 32'(step_valid), (c == 1 || c == 3 || c == 8) ? 1 : 0);
      check($sformatf("basic_busy c%0d", c),  32'(busy),       (c < 8) ? 1 : 0);
      check($sformatf("basic_done c%0d", c),  32'(done),       (c >= 8) ? 1 : 0);
      if (c == 8) check("basic_idx", 32'(step_idx), 2);
      tick();
    end

    // Hold during cycles 1-2 delays later steps by two cycles
    go(3);
    for (int c = 0; c <= 11; c++) begin
      ev = (c < 1) ? 15 : (c < 5) ? 1 : (c < 10) ? 3 : 15;
      check($sformatf("hold_vec c%0d", c),   32'(stim_vec),   ev);
      check($sformatf("hold_valid c%0d", c), 32'(step_valid), (c == 1 || c == 5 || c == 10) ? 1 : 0);
      check($sformatf("hold_done c%0d", c),  32'(done),       (c >= 10) ? 1 : 0);
      hold = (c == 1 || c == 2);
      tick();
    end
    hold = 1'b0;

    // Slip: {5:A, 5:B, 3:C} issue back to back
    load('{step_time: 16'd5, vec: 4'hA}, 0);
    load('{step_time: 16'd5, vec: 4'hB}, 1);
    load('{step_time: 16'd3, vec: 4'hC}, 2);
    go(3);
    for (int c = 0; c <= 9; c++) begin
      ev = (c < 6) ? 15 : (c == 6) ? 10 : (c == 7) ? 11 : 12;
      check($sformatf("slip_vec c%0d", c),   32'(stim_vec),   ev);
      check($sformatf("slip_valid c%0d", c), 32'(step_valid), (c >= 6 && c <= 8) ? 1 : 0);
      if (c == 8) check("slip_idx", 32'(step_idx), 2);
      tick();
    end

    // Abort at cycle 4 of the basic run
    load('{step_time: 16'd0, vec: 4'h1}, 0);
    load('{step_time: 16'd2, vec: 4'h3}, 1);
    load('{step_time: 16'd7, vec: 4'hF}, 2);
    go(3);
    for (int c = 0; c <= 9; c++) begin
      ev = (c < 1) ? 12 : (c < 3) ? 1 : 3;
      check($sformatf("abort_vec c%0d", c),   32'(stim_vec),   ev);
      check($sformatf("abort_valid c%0d", c), 32'(step_valid), (c == 1 || c == 3) ? 1 : 0);
      check($sformatf("abort_busy c%0d", c),  32'(busy),       (c <= 4) ? 1 : 0);
      check($sformatf("abort_done c%0d", c),  32'(done),       0);
      abort = (c == 4);
      tick();
    end
    abort = 1'b0;

    // Load attempted during RUN must not change entry 2
    go(3);
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) begin
        load_en = 1'b1; load_addr = 4'd2; load_time = 16'd7; load_vec = 4'h0;
      end else begin
        load_en = 1'b0;
      end
      if (c == 8) begin
        check("runload_vec",   32'(stim_vec),   15);
        check("runload_valid", 32'(step_valid), 1);
        check("runload_done",  32'(done),       1);
      end
      tick();
    end
    load_en = 1'b0;

    // Load and start in the same cycle: run sees the new entry
    load_en = 1'b1; load_addr = 4'd0; load_time = 16'd0; load_vec = 4'h9;
    go(1);
    load_en = 1'b0;
    check("ldstart_busy0", 32'(busy), 1);
    tick();
    check("ldstart_vec",   32'(stim_vec),   9);
    check("ldstart_valid", 32'(step_valid), 1);
    check("ldstart_done",  32'(done),       1);
    check("ldstart_busy1", 32'(busy),       0);
    check("ldstart_idx",   32'(step_idx),   0);
    tick();

    // num_steps = 0 finishes immediately
    go(0);
    for (int c = 0; c <= 2; c++) begin
      check($sformatf("zero_done c%0d", c),  32'(done),       1);
      check($sformatf("zero_busy c%0d", c),  32'(busy),       0);
      check($sformatf("zero_valid c%0d", c), 32'(step_valid), 0);
      check($sformatf("zero_vec c%0d", c),   32'(stim_vec),   9);
      tick();
    end

    // Reset mid-run
    load('{step_time: 16'd0, vec: 4'h1}, 0);
    go(3);
    repeat (4) tick();
    check("midrst_pre_vec",  32'(stim_vec), 3);
    check("midrst_pre_busy", 32'(busy),     1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_vec",   32'(stim_vec),   0);
    check("midrst_idx",   32'(step_idx),   0);
    check("midrst_busy",  32'(busy),       0);
    check("midrst_done",  32'(done),       0);
    check("midrst_valid", 32'(step_valid), 0);
    tick();

    // Saturation on the 4-bit counter: slipped entries at time 15 still issue
    load('{step_time: 16'd15, vec: 4'h5}, 0);
    load('{step_time: 16'd15, vec: 4'h6}, 1);
    load('{step_time: 16'd15, vec: 4'h7}, 2);
    num_steps = 5'd3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c <= 19; c++) begin
      ev = (c < 16) ? 0 : (c == 16) ? 5 : (c == 17) ? 6 : 7;
      check($sformatf("sat_vec c%0d", c),   32'(stim_vec2),   ev);
      check($sformatf("sat_valid c%0d", c), 32'(step_valid2), (c >= 16 && c <= 18) ? 1 : 0);
      check($sformatf("sat_done c%0d", c),  32'(done2),       (c >= 18) ? 1 : 0);
      if (c == 17) check("sat_counter", 32'(dut2.counter), 15);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
